// File: rtl/c432_key_loader_if.sv
// c432_key_loader_if: serial key link and committed-key outputs of the c432 key loader
interface c432_key_loader_if #(
  parameter int KEY_WIDTH = 12
);
  logic                 load_start;
  logic                 kin_valid;
  logic                 kin_data;
  logic                 kin_ready;
  logic [KEY_WIDTH-1:0] key_out;
  logic                 key_valid;
  logic                 load_busy;
  logic                 load_error;
  modport master (
    output load_start, kin_valid, kin_data,
    input  kin_ready, key_out, key_valid, load_busy, load_error
  );
  modport slave (
    input  load_start, kin_valid, kin_data,
    output kin_ready, key_out, key_valid, load_busy, load_error
  );
endinterface

// File: rtl/c432_key_loader.sv
// c432_key_loader: assembles a serial key in a hidden shadow register and commits it to the c432 core
module c432_key_loader #(
  parameter int                   KEY_WIDTH = 12,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
  parameter bit                   PARITY_EN = 1'b1,
  parameter int                   TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst_n,
  c432_key_loader_if.slave bus
);
  localparam int CW = $clog2(KEY_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, COMMIT, ERROR} state_t;
  state_t               state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CW-1:0]        bit_cnt;
  logic [7:0]           tmo_cnt;
  logic                 accept;
  logic                 to_err;
  logic                 last_bit;
  assign accept   = bus.kin_valid & bus.kin_ready;
  assign last_bit = bit_cnt == CW'(KEY_WIDTH - 1);
  // Failure is either a bad parity bit or an idle link that ran out the timeout
  always_comb begin
    to_err = 1'b0;
    to_err = (state == SHIFT || state == PARITY) &&
             (accept ? (state == PARITY && (^{shadow, bus.kin_data})) : tmo_cnt == 8'(TIMEOUT));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shadow         <= '0;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      bus.key_out    <= DECOY_KEY;
      bus.key_valid  <= 1'b0;
      bus.kin_ready  <= 1'b0;
      bus.load_busy  <= 1'b0;
      bus.load_error <= 1'b0;
    end else if (to_err) begin
      state          <= ERROR;
      shadow         <= '0;
      bus.key_out    <= DECOY_KEY;
      bus.key_valid  <= 1'b0;
      bus.kin_ready  <= 1'b0;
      bus.load_busy  <= 1'b0;
      bus.load_error <= 1'b1;
    end else begin
      case (state)
        IDLE, ERROR: if (bus.load_start) begin
          state          <= SHIFT;
          shadow         <= '0;
          bit_cnt        <= '0;
          tmo_cnt        <= '0;
          bus.key_out    <= DECOY_KEY;
          bus.key_valid  <= 1'b0;
          bus.load_error <= 1'b0;
          bus.kin_ready  <= 1'b1;
          bus.load_busy  <= 1'b1;
        end
        SHIFT, PARITY: if (accept) begin
          tmo_cnt <= '0;
          if (state == SHIFT) begin
            shadow[bit_cnt] <= bus.kin_data;
            bit_cnt         <= bit_cnt + CW'(1);
            if (last_bit) begin
              state         <= PARITY_EN ? PARITY : COMMIT;
              bus.kin_ready <= PARITY_EN;
            end
          end else begin
            state         <= COMMIT;
            bus.kin_ready <= 1'b0;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
        COMMIT: begin
          state         <= IDLE;
          bus.key_out   <= shadow;
          bus.key_valid <= 1'b1;
          bus.load_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
